// File: rtl/video_out_hmag_tap_if.sv
// Bus between the horizontal magnifier, its line buffer and the bilinear blender.
// The master side drives line control and read data; the slave side is the magnifier.
interface video_out_hmag_tap_if;
  logic        line_start;
  logic [9:0]  src_width;
  logic [10:0] dst_width;
  logic [6:0]  step;
  logic [9:0]  rd_address;
  logic [5:0]  rd_data;
  logic [5:0]  tap0;
  logic [5:0]  tap1;
  logic [5:0]  coeff;
  logic        valid;

  modport master (
    output line_start, src_width, dst_width, step, rd_data,
    input  rd_address, tap0, tap1, coeff, valid
  );

  modport slave (
    input  line_start, src_width, dst_width, step, rd_data,
    output rd_address, tap0, tap1, coeff, valid
  );
endinterface

// File: rtl/video_out_hmag_tap.sv
// Horizontal magnifier front end: walks one buffered source line with a 10.6 phase
// accumulator and emits (tap0, tap1, coeff) per output pixel. Option: VIDEO_OUT_HMAG_HALF_PHASE_EN.
module video_out_hmag_tap (
  input logic                 clk,
  input logic                 reset,
  video_out_hmag_tap_if.slave bus
);
  localparam int DATA_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    PRIME0,
    PRIME1,
    PRIME2,
    ACTIVE
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         acc_q, acc_d;
  logic [10:0]         cnt_q, cnt_d;
  logic [9:0]          src_w_q, src_w_d;
  logic [10:0]         dst_w_q, dst_w_d;
  logic [6:0]          step_q, step_d;
  logic [9:0]          rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   tap0_q, tap0_d;
  logic [DATA_W-1:0]   tap1_q, tap1_d;
  logic [DATA_W-1:0]   coeff_q, coeff_d;
  logic                valid_q, valid_d;

  logic [6:0]          step_in_eff;
  logic [15:0]         acc_init;
  logic [15:0]         acc_step;
  logic [15:0]         acc_ahead;
  logic                int_inc;
  logic [10:0]         cnt_inc;

  // Saturate the requested step to 1.0: the block only magnifies.
  function automatic logic [6:0] step_sat(input logic [6:0] s);
    return (s > 7'd64) ? 7'd64 : s;
  endfunction

  // Clamp a source index to the last pixel of the line so the right edge repeats.
  function automatic logic [9:0] clamp_idx(input logic [10:0] x, input logic [9:0] w);
    logic [9:0] last;
    last = w - 10'd1;
    return (x > {1'b0, last}) ? last : x[9:0];
  endfunction

  // Integer part plus a fixed offset, widened so indices near 1023 do not wrap before clamping.
  function automatic logic [10:0] int_plus(input logic [15:0] a, input logic [10:0] off);
    return {1'b0, a[15:6]} + off;
  endfunction

  assign step_in_eff = step_sat(bus.step);

`ifdef VIDEO_OUT_HMAG_HALF_PHASE_EN
  assign acc_init = {10'd0, step_in_eff[6:1]};
`else
  assign acc_init = 16'd0;
`endif

  // acc_step is the phase of the next output pixel; acc_ahead is one further, which is
  // what the read address must track because read data arrives a clock late.
  assign acc_step  = acc_q + {9'd0, step_q};
  assign acc_ahead = acc_step + {9'd0, step_q};
  assign int_inc   = (acc_step[15:6] != acc_q[15:6]);
  assign cnt_inc   = cnt_q + 11'd1;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    src_w_d   = src_w_q;
    dst_w_d   = dst_w_q;
    step_d    = step_q;
    rd_addr_d = rd_addr_q;
    tap0_d    = tap0_q;
    tap1_d    = tap1_q;
    coeff_d   = coeff_q;
    valid_d   = valid_q;

    if (bus.line_start) begin
      state_d   = PRIME0;
      acc_d     = acc_init;
      cnt_d     = 11'd0;
      src_w_d   = bus.src_width;
      dst_w_d   = bus.dst_width;
      step_d    = step_in_eff;
      rd_addr_d = 10'd0;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_d = 1'b0;
        end
        PRIME0: begin
          state_d   = PRIME1;
          rd_addr_d = clamp_idx(11'd1, src_w_q);
        end
        PRIME1: begin
          state_d   = PRIME2;
          rd_addr_d = clamp_idx(11'd2, src_w_q);
          tap0_d    = bus.rd_data;
        end
        PRIME2: begin
          tap1_d = bus.rd_data;
          if (dst_w_q != 11'd0) begin
            state_d   = ACTIVE;
            valid_d   = 1'b1;
            coeff_d   = acc_q[5:0];
            rd_addr_d = clamp_idx(int_plus(acc_step, 11'd2), src_w_q);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end
        ACTIVE: begin
          acc_d     = acc_step;
          coeff_d   = acc_step[5:0];
          rd_addr_d = clamp_idx(int_plus(acc_ahead, 11'd2), src_w_q);
          cnt_d     = cnt_inc;
          if (int_inc) begin
            tap0_d = tap1_q;
            tap1_d = bus.rd_data;
          end
          if (cnt_inc == dst_w_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
          end else begin
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Register stage: every output leaves the block straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= 16'd0;
      cnt_q     <= 11'd0;
      src_w_q   <= 10'd0;
      dst_w_q   <= 11'd0;
      step_q    <= 7'd0;
      rd_addr_q <= 10'd0;
      tap0_q    <= '0;
      tap1_q    <= '0;
      coeff_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      src_w_q   <= src_w_d;
      dst_w_q   <= dst_w_d;
      step_q    <= step_d;
      rd_addr_q <= rd_addr_d;
      tap0_q    <= tap0_d;
      tap1_q    <= tap1_d;
      coeff_q   <= coeff_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.rd_address = rd_addr_q;
  assign bus.tap0       = tap0_q;
  assign bus.tap1       = tap1_q;
  assign bus.coeff      = coeff_q;
  assign bus.valid      = valid_q;

endmodule

// File: tb/tb_video_out_hmag_tap.sv
// Directed bench for video_out_hmag_tap; the line buffer returns address[5:0] one clock late.
module tb_video_out_hmag_tap;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  video_out_hmag_tap_if bus ();

  video_out_hmag_tap dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.rd_data <= bus.rd_address[5:0];

  // Pulse line_start so it is sampled at one posedge; returns at the negedge inside PRIME0.
  task automatic start_line(input logic [9:0] sw, input logic [10:0] dw, input logic [6:0] st);
    @(negedge clk);
    bus.src_width  = sw;
    bus.dst_width  = dw;
    bus.step       = st;
    bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0d want 0", bus.valid); end
    n_vec++; if (bus.rd_address !== 10'd0) begin n_bad++; $display("FAIL reset_addr got %0d want 0", bus.rd_address); end
    n_vec++; if (bus.tap0 !== 6'd0) begin n_bad++; $display("FAIL reset_tap0 got %0d want 0", bus.tap0); end
    n_vec++; if (bus.tap1 !== 6'd0) begin n_bad++; $display("FAIL reset_tap1 got %0d want 0", bus.tap1); end
    n_vec++; if (bus.coeff !== 6'd0) begin n_bad++; $display("FAIL reset_coeff got %0d want 0", bus.coeff); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_half_step;
    logic [5:0] e0 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    logic [5:0] e1 [8] = '{1, 1, 2, 2, 3, 3, 4, 4};
    logic [5:0] ec [8] = '{0, 32, 0, 32, 0, 32, 0, 32};
    logic [9:0] ea [3] = '{0, 1, 2};
    start_line(10'd512, 11'd8, 7'd32);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      n_vec++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL latency_valid p%0d got %0d want 0", i, bus.valid); end
      n_vec++; if (bus.rd_address !== ea[i]) begin n_bad++; $display("FAIL prime_addr p%0d got %0d want %0d", i, bus.rd_address, ea[i]); end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_vec++; if (bus.valid !== 1'b1) begin n_bad++; $display("FAIL half_valid o%0d got %0d want 1", i, bus.valid); end
      n_vec++; if (bus.tap0 !== e0[i]) begin n_bad++; $display("FAIL half_tap0 o%0d got %0d want %0d", i, bus.tap0, e0[i]); end
      n_vec++; if (bus.tap1 !== e1[i]) begin n_bad++; $display("FAIL half_tap1 o%0d got %0d want %0d", i, bus.tap1, e1[i]); end
      n_vec++; if (bus.coeff !== ec[i]) begin n_bad++; $display("FAIL half_coeff o%0d got %0d want %0d", i, bus.coeff, ec[i]); end
    end
    @(negedge clk);
    n_vec++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL half_end_valid got %0d want 0", bus.valid); end
  endtask

  task automatic test_right_edge;
    logic [5:0] e0 [6] = '{0, 1, 2, 3, 3, 3};
    logic [5:0] e1 [6] = '{1, 2, 3, 3, 3, 3};
    start_line(10'd4, 11'd6, 7'd64);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      n_vec++; if (bus.rd_address > 10'd3) begin n_bad++; $display("FAIL edge_addr c%0d got %0d want <=3", i, bus.rd_address); end
      if (i >= 3) begin
        n_vec++; if (bus.valid !== 1'b1) begin n_bad++; $display("FAIL edge_valid o%0d got %0d want 1", i-3, bus.valid); end
        n_vec++; if (bus.tap0 !== e0[i-3]) begin n_bad++; $display("FAIL edge_tap0 o%0d got %0d want %0d", i-3, bus.tap0, e0[i-3]); end
        n_vec++; if (bus.tap1 !== e1[i-3]) begin n_bad++; $display("FAIL edge_tap1 o%0d got %0d want %0d", i-3, bus.tap1, e1[i-3]); end
        n_vec++; if (bus.coeff !== 6'd0) begin n_bad++; $display("FAIL edge_coeff o%0d got %0d want 0", i-3, bus.coeff); end
      end
    end
    @(negedge clk);
    n_vec++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL edge_end_valid got %0d want 0", bus.valid); end
  endtask

  task automatic test_step_clamp;
    logic [5:0] e0 [3] = '{0, 1, 2};
    logic [5:0] e1 [3] = '{1, 2, 3};
    start_line(10'd512, 11'd3, 7'd100);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (bus.valid !== 1'b1) begin n_bad++; $display("FAIL clamp_valid o%0d got %0d want 1", i, bus.valid); end
      n_vec++; if (bus.tap0 !== e0[i]) begin n_bad++; $display("FAIL clamp_tap0 o%0d got %0d want %0d", i, bus.tap0, e0[i]); end
      n_vec++; if (bus.tap1 !== e1[i]) begin n_bad++; $display("FAIL clamp_tap1 o%0d got %0d want %0d", i, bus.tap1, e1[i]); end
      n_vec++; if (bus.coeff !== 6'd0) begin n_bad++; $display("FAIL clamp_coeff o%0d got %0d want 0", i, bus.coeff); end
    end
    @(negedge clk);
    n_vec++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL clamp_end_valid got %0d want 0", bus.valid); end
  endtask

  task automatic test_step_zero;
    start_line(10'd512, 11'd3, 7'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (bus.valid !== 1'b1) begin n_bad++; $display("FAIL zero_valid o%0d got %0d want 1", i, bus.valid); end
      n_vec++; if (bus.tap0 !== 6'd0) begin n_bad++; $display("FAIL zero_tap0 o%0d got %0d want 0", i, bus.tap0); end
      n_vec++; if (bus.tap1 !== 6'd1) begin n_bad++; $display("FAIL zero_tap1 o%0d got %0d want 1", i, bus.tap1); end
      n_vec++; if (bus.coeff !== 6'd0) begin n_bad++; $display("FAIL zero_coeff o%0d got %0d want 0", i, bus.coeff); end
    end
    @(negedge clk);
    n_vec++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL zero_end_valid got %0d want 0", bus.valid); end
  endtask

  task automatic test_restart_reset;
    logic [5:0] e0 [5] = '{0, 0, 1, 1, 2};
    logic [5:0] e1 [5] = '{1, 1, 2, 2, 3};
    logic [5:0] ec [5] = '{0, 32, 0, 32, 0};
    start_line(10'd512, 11'd8, 7'd32);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (bus.tap0 !== e0[i] || bus.tap1 !== e1[i] || bus.coeff !== ec[i] || bus.valid !== 1'b1)
      begin n_bad++; $display("FAIL restart_pre o%0d got %0d/%0d/%0d v%0d want %0d/%0d/%0d v1",
                              i, bus.tap0, bus.tap1, bus.coeff, bus.valid, e0[i], e1[i], ec[i]); end
    end
    bus.line_start = 1'b1;
    @(negedge clk);
    bus.line_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      n_vec++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL restart_gap c%0d got %0d want 0", i, bus.valid); end
    end
    @(negedge clk);
    n_vec++; if (bus.tap0 !== 6'd0 || bus.tap1 !== 6'd1 || bus.coeff !== 6'd0 || bus.valid !== 1'b1)
    begin n_bad++; $display("FAIL restart_first got %0d/%0d/%0d v%0d want 0/1/0 v1", bus.tap0, bus.tap1, bus.coeff, bus.valid); end
    @(negedge clk);
    n_vec++; if (bus.tap0 !== 6'd0 || bus.tap1 !== 6'd1 || bus.coeff !== 6'd32 || bus.valid !== 1'b1)
    begin n_bad++; $display("FAIL restart_second got %0d/%0d/%0d v%0d want 0/1/32 v1", bus.tap0, bus.tap1, bus.coeff, bus.valid); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid got %0d want 0", bus.valid); end
    n_vec++; if (bus.rd_address !== 10'd0) begin n_bad++; $display("FAIL midreset_addr got %0d want 0", bus.rd_address); end
    n_vec++; if (bus.tap0 !== 6'd0) begin n_bad++; $display("FAIL midreset_tap0 got %0d want 0", bus.tap0); end
    n_vec++; if (bus.tap1 !== 6'd0) begin n_bad++; $display("FAIL midreset_tap1 got %0d want 0", bus.tap1); end
    n_vec++; if (bus.coeff !== 6'd0) begin n_bad++; $display("FAIL midreset_coeff got %0d want 0", bus.coeff); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL midreset_idle c%0d got %0d want 0", i, bus.valid); end
    end
  endtask

  task automatic test_dst_zero;
    start_line(10'd512, 11'd0, 7'd32);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      n_vec++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL dst0_valid c%0d got %0d want 0", i, bus.valid); end
    end
  endtask

  task automatic test_src_one;
    start_line(10'd1, 11'd4, 7'd32);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++; if (bus.valid !== 1'b1) begin n_bad++; $display("FAIL src1_valid o%0d got %0d want 1", i, bus.valid); end
      n_vec++; if (bus.tap0 !== 6'd0 || bus.tap1 !== 6'd0) begin n_bad++; $display("FAIL src1_taps o%0d got %0d/%0d want 0/0", i, bus.tap0, bus.tap1); end
      n_vec++; if (bus.rd_address !== 10'd0) begin n_bad++; $display("FAIL src1_addr o%0d got %0d want 0", i, bus.rd_address); end
    end
    @(negedge clk);
    n_vec++; if (bus.valid !== 1'b0) begin n_bad++; $display("FAIL src1_end_valid got %0d want 0", bus.valid); end
  endtask

  initial begin
    n_vec          = 0;
    n_bad          = 0;
    reset          = 1'b1;
    bus.line_start = 1'b0;
    bus.src_width  = 10'd512;
    bus.dst_width  = 11'd0;
    bus.step       = 7'd0;
    test_reset();
    test_half_step();
    test_right_edge();
    test_step_clamp();
    test_step_zero();
    test_restart_reset();
    test_dst_zero();
    test_src_one();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
